lu_stream_engine: RTL

Sequential streaming front end for the 32-bit logical unit. Commands (opcode plus two operands) arrive over a valid/ready interface, are buffered in a small FIFO, and are evaluated one per cycle. Results are held in an output register until the consumer accepts them. The block lets pipelined datapaths issue logic operations without stalling on the consumer, and returns each result tagged with its opcode.

---
 rtl/lu_pkg.sv | 22 ++
 rtl/lu_cmd_fifo.sv | 70 +++++++
 rtl/lu_stream_engine.sv | 112 +++++++++++
 3 files changed

// File: rtl/lu_pkg.sv
// Shared definitions for the logical-unit stream engine: opcodes, default width
// and the command record carried through the command FIFO.
package lu_pkg;

   localparam int LU_DW = 32;

   localparam logic [2:0] LU_AND  = 3'b000;
   localparam logic [2:0] LU_XOR  = 3'b001;
   localparam logic [2:0] LU_NAND = 3'b010;
   localparam logic [2:0] LU_OR   = 3'b011;
   localparam logic [2:0] LU_NOT  = 3'b100;
   localparam logic [2:0] LU_NOR  = 3'b101;
   localparam logic [2:0] LU_NEG  = 3'b110;
   localparam logic [2:0] LU_XNOR = 3'b111;

   typedef struct packed {
      logic [2:0]       opt;
      logic [LU_DW-1:0] a;
      logic [LU_DW-1:0] b;
   } lu_cmd_t;

endpackage

// File: rtl/lu_cmd_fifo.sv
// Synchronous command FIFO with an asynchronously readable head entry so the
// consumer can evaluate the head in the same cycle it pops it.
module lu_cmd_fifo
   import lu_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type cmd_t = lu_cmd_t
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  cmd_t                     wr_data,
   input  logic                     pop,
   output cmd_t                     rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic [AW:0]   count_next;
   logic          do_push;
   logic          do_pop;
   cmd_t          mem [DEPTH];

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr_reg];
   assign count   = count_reg;

   // Storage is not reset; occupancy alone decides which entries are live.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg == AW'(gi))) begin
               mem[gi] <= wr_data;
            end
         end
      end
   endgenerate

   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + (AW+1)'(1);
         2'b01:   count_next = count_reg - (AW+1)'(1);
         default: count_next = count_reg;
      endcase
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/lu_stream_engine.sv
// Streaming front end for the 32-bit logical unit: FIFO-buffered commands,
// one evaluation per cycle, held result register. Option: LU_ZERO_FLAG_EN.
module lu_stream_engine
   import lu_pkg::*;
#(
   parameter int DW    = LU_DW,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_opt,
   input  logic [DW-1:0]            in_a,
   input  logic [DW-1:0]            in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DW-1:0]            out_ans,
   output logic [2:0]               out_opt,
   output logic                     out_zero,
   output logic [$clog2(DEPTH):0]   count
);

   typedef struct packed {
      logic [2:0]    opt;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } cmd_t;

   cmd_t          wr_cmd;
   cmd_t          head;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [DW-1:0] result;
   logic          out_valid_reg;
   logic [DW-1:0] ans_reg;
   logic [2:0]    opt_reg;

   assign wr_cmd = '{opt: in_opt, a: in_a, b: in_b};

   // in_ready comes from registered occupancy only, never from out_ready.
   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign pop      = !empty && (!out_valid_reg || out_ready);

   lu_cmd_fifo #(
      .DEPTH (DEPTH),
      .cmd_t (cmd_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data (wr_cmd),
      .pop     (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   always_comb begin
      result = '0;
      case (head.opt)
         LU_AND:  result = head.a & head.b;
         LU_XOR:  result = head.a ^ head.b;
         LU_NAND: result = ~(head.a & head.b);
         LU_OR:   result = head.a | head.b;
         LU_NOT:  result = ~head.b;
         LU_NOR:  result = ~(head.a | head.b);
         LU_NEG:  result = ~head.b + DW'(1);
         LU_XNOR: result = ~(head.a ^ head.b);
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         ans_reg       <= '0;
         opt_reg       <= '0;
      end else if (pop) begin
         out_valid_reg <= 1'b1;
         ans_reg       <= result;
         opt_reg       <= head.opt;
      end else if (out_valid_reg && out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_ans   = ans_reg;
   assign out_opt   = opt_reg;

`ifdef LU_ZERO_FLAG_EN
   logic zero_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         zero_reg <= 1'b0;
      end else if (pop) begin
         zero_reg <= (result == '0);
      end
   end

   assign out_zero = zero_reg;
`else
   assign out_zero = 1'b0;
`endif

endmodule
